// File: rtl/cmp_pkg.sv
// Shared definitions for the serial compare controller: FSM state
// encodings and the bit-counter width helper.
package cmp_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Bit-index counter width; a 1-bit operand still needs a 1-bit counter.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/comparator.sv
// 1-bit equality cell: z is high when x and y match.
module comparator (
    input  logic x,
    input  logic y,
    output logic z
);

    assign z = ~(x ^ y);

endmodule

// File: rtl/serial_compare_ctrl.sv
// Serial magnitude comparator controller. Walks two latched operands
// MSB first through a single shared 1-bit comparator cell and stops at
// the first mismatching bit pair.
module serial_compare_ctrl
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter bit          SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    localparam int unsigned   CW      = cnt_width(WIDTH);
    localparam logic [CW-1:0] IDX_MSB = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             eq_q, eq_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;

    logic [WIDTH-1:0] a_sh, b_sh;
    logic             bit_a, bit_b;
    logic             bits_match;

    // Select the current bit pair by shifting, so the counter may be wider
    // than the operand index range (WIDTH=1 or non-power-of-two widths).
    always_comb begin
        a_sh  = a_q >> idx_q;
        b_sh  = b_q >> idx_q;
        bit_a = a_sh[0];
        bit_b = b_sh[0];
    end

    comparator u_cmp (
        .x (bit_a),
        .y (bit_b),
        .z (bits_match)
    );

    // Next-state logic: operand capture, bit walk and result decision.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = IDX_MSB;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (!bits_match) begin
                    state_d = DONE;
                    eq_d    = 1'b0;
                    // A sign-bit mismatch means the operand with the 1 is negative.
                    if (SIGNED && (idx_q == IDX_MSB)) begin
                        gt_d = bit_b;
                        lt_d = bit_a;
                    end else begin
                        gt_d = bit_a;
                        lt_d = bit_b;
                    end
                end else if (idx_q == '0) begin
                    state_d = DONE;
                    eq_d    = 1'b1;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                end else begin
                    idx_d = idx_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= IDX_MSB;
            a_q     <= '0;
            b_q     <= '0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign eq   = eq_q;
    assign gt   = gt_q;
    assign lt   = lt_q;

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Bench for serial_compare_ctrl: an unsigned and a signed 8-bit instance
// share stimulus; a 1-bit instance runs alongside on bit 0 of the operands.
module tb_serial_compare_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start8 = 1'b0;
    logic       start1 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic [2:0] busy_w, done_w, eq_w, gt_w, lt_w;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_compare_ctrl #(.WIDTH(8), .SIGNED(1'b0)) dut_u (
        .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8),
        .busy(busy_w[0]), .done(done_w[0]), .eq(eq_w[0]), .gt(gt_w[0]), .lt(lt_w[0])
    );

    serial_compare_ctrl #(.WIDTH(8), .SIGNED(1'b1)) dut_s (
        .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8),
        .busy(busy_w[1]), .done(done_w[1]), .eq(eq_w[1]), .gt(gt_w[1]), .lt(lt_w[1])
    );

    serial_compare_ctrl #(.WIDTH(1), .SIGNED(1'b0)) dut_1 (
        .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1),
        .busy(busy_w[2]), .done(done_w[2]), .eq(eq_w[2]), .gt(gt_w[2]), .lt(lt_w[2])
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        int         lat_u;
        int         lat_s;
        logic [2:0] res_u;   // {eq, gt, lt}
        logic [2:0] res_s;
    } vec_t;

    vec_t tbl[7];

    // Reference: cycles from accept to done = matching MSBs + 2, or w+1 if equal.
    function automatic int exp_lat(input logic [31:0] x, input logic [31:0] y, input int w);
        for (int i = w - 1; i >= 0; i--) begin
            if (x[i] != y[i]) return (w - 1 - i) + 2;
        end
        return w + 1;
    endfunction

    // Reference: numeric comparison of w-bit values, signed or unsigned.
    function automatic logic [2:0] exp_res(input logic [31:0] x, input logic [31:0] y,
                                           input int w, input bit sgn);
        longint m, vx, vy;
        m  = (longint'(1) << w) - 1;
        vx = longint'(x) & m;
        vy = longint'(y) & m;
        if (sgn && vx >= (longint'(1) << (w - 1))) vx = vx - (longint'(1) << w);
        if (sgn && vy >= (longint'(1) << (w - 1))) vy = vy - (longint'(1) << w);
        return {vx == vy, vx > vy, vx < vy};
    endfunction

    task automatic chk(input string nm, input int d, input int k,
                       input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s dut%0d cycle%0d actual=%0h required=%0h", nm, d, k, act, expv);
        end
    endtask

    task automatic chk_cycle(input int d, input int k, input int lat, input logic [2:0] res);
        chk("done", d, k, 32'(done_w[d]), 32'(k == lat));
        chk("busy", d, k, 32'(busy_w[d]), 32'(k < lat));
        if (k >= lat) chk("result", d, k, 32'({eq_w[d], gt_w[d], lt_w[d]}), 32'(res));
    endtask

    // Start one comparison on all instances and follow it cycle by cycle.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_,
                          input int lat_u, input int lat_s,
                          input logic [2:0] res_u, input logic [2:0] res_s);
        int         lat[3];
        logic [2:0] res[3];
        lat[0] = lat_u; res[0] = res_u;
        lat[1] = lat_s; res[1] = res_s;
        lat[2] = exp_lat(32'(ta[0]), 32'(tb_[0]), 1);
        res[2] = exp_res(32'(ta[0]), 32'(tb_[0]), 1, 1'b0);
        @(negedge clk);
        a8 = ta; b8 = tb_; a1 = ta[0]; b1 = tb_[0];
        start8 = 1'b1; start1 = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) chk_cycle(d, k, lat[d], res[d]);
            if (k == 1) begin
                // Operand changes while running must not matter.
                start8 = 1'b0; start1 = 1'b0;
                a8 = 8'($urandom); b8 = 8'($urandom);
                a1 = 1'($urandom); b1 = 1'($urandom);
            end
        end
    endtask

    initial begin
        tbl[0] = '{8'hA5, 8'hA5, 9, 9, 3'b100, 3'b100};
        tbl[1] = '{8'h80, 8'h7F, 2, 2, 3'b010, 3'b001};
        tbl[2] = '{8'h12, 8'h13, 9, 9, 3'b001, 3'b001};
        tbl[3] = '{8'h30, 8'h20, 5, 5, 3'b010, 3'b010};
        tbl[4] = '{8'h00, 8'hFF, 2, 2, 3'b001, 3'b010};
        tbl[5] = '{8'h7F, 8'h80, 2, 2, 3'b001, 3'b010};
        tbl[6] = '{8'hFF, 8'hFE, 9, 9, 3'b010, 3'b010};

        // Reset state
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("rst_busy", d, 0, 32'(busy_w[d]), 0);
            chk("rst_done", d, 0, 32'(done_w[d]), 0);
            chk("rst_res", d, 0, 32'({eq_w[d], gt_w[d], lt_w[d]}), 0);
        end
        reset = 1'b0;

        // Directed vectors
        for (int i = 0; i < 7; i++)
            run_op(tbl[i].a, tbl[i].b, tbl[i].lat_u, tbl[i].lat_s, tbl[i].res_u, tbl[i].res_s);

        // Start while busy is ignored; start during done is accepted back-to-back
        @(negedge clk);
        a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                chk("b2b_done", d, k, 32'(done_w[d]), 32'(k == 9 || k == 18));
                chk("b2b_busy", d, k, 32'(busy_w[d]), 32'(k < 9 || (k >= 10 && k < 18)));
                if (k >= 9)
                    chk("b2b_res", d, k, 32'({eq_w[d], gt_w[d], lt_w[d]}),
                        (k < 18) ? 32'b100 : 32'b001);
            end
            if (k == 1) start8 = 1'b0;
            if (k == 3) begin start8 = 1'b1; a8 = 8'hFF; b8 = 8'h00; end
            if (k == 4) begin start8 = 1'b0; a8 = 8'h01; b8 = 8'h01; end
            if (k == 9) begin start8 = 1'b1; a8 = 8'h00; b8 = 8'h01; end
            if (k == 10) start8 = 1'b0;
        end

        // Reset mid-run, coinciding with a start request
        @(negedge clk);
        a8 = 8'h00; b8 = 8'h00; start8 = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                chk("rstrun_busy", d, k, 32'(busy_w[d]), 32'(k <= 4));
                chk("rstrun_done", d, k, 32'(done_w[d]), 0);
            end
            if (k >= 5)
                for (int d = 0; d < 3; d++)
                    chk("rstrun_res", d, k, 32'({eq_w[d], gt_w[d], lt_w[d]}), 0);
            if (k == 1) start8 = 1'b0;
            if (k == 4) begin reset = 1'b1; start8 = 1'b1; end
            if (k == 5) begin reset = 1'b0; start8 = 1'b0; end
        end
        run_op(8'h30, 8'h20, 5, 5, 3'b010, 3'b010);

        // Randomized operands against the reference model
        for (int i = 0; i < 60; i++) begin
            logic [7:0] ra, rb;
            int         mode;
            ra   = 8'($urandom);
            mode = $urandom_range(0, 2);
            if (mode == 0)      rb = ra;
            else if (mode == 1) rb = ra ^ (8'h01 << $urandom_range(0, 7));
            else                rb = 8'($urandom);
            run_op(ra, rb, exp_lat(32'(ra), 32'(rb), 8), exp_lat(32'(ra), 32'(rb), 8),
                   exp_res(32'(ra), 32'(rb), 8, 1'b0), exp_res(32'(ra), 32'(rb), 8, 1'b1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
